fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_W, default 8, SHALL set the program counter width (instruction-memory word address width).
REQ-002 Parameter RESET_PC, default 0, SHALL set the PC value loaded on reset.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous active-high reset.
REQ-006 run  input  1  SHALL be the start/resume request, sampled each cycle.
REQ-007 step  input  1  SHALL be the single-instruction-step request, sampled each cycle.
REQ-008 bs  input  3  SHALL be the branch select from the decoder.
REQ-009 off  input  6  SHALL be the two's-complement branch offset from the decoder.
REQ-010 halt  input  1  SHALL be the halt flag from the decoder.
REQ-011 zero  input  1  SHALL be the ALU result-is-zero flag for the current instruction.
REQ-012 neg  input  1  SHALL be the ALU result-is-negative flag for the current instruction.
REQ-013 pc  output  PC_W  SHALL be the current PC, driving the instruction-memory address.
REQ-014 instr_valid  output  1  SHALL mark the current instruction as executing; downstream gates LD and MW with it.
REQ-015 halted  output  1  SHALL be high while in state HALTED.
REQ-016 retire_cnt  output  16  SHALL be the retired-instruction count (see Configuration).

Function
REQ-017 States: IDLE, RUN, STEP, HALTED; instr_valid SHALL be 1 only in RUN and STEP.
REQ-018 IDLE/HALTED: run=1 -> RUN; else step=1 -> STEP; else hold. run and step together -> RUN.
REQ-019 RUN: run and step ignored; halt=1 -> HALTED; else stay RUN.
REQ-020 STEP SHALL last exactly one cycle, then go to HALTED regardless of halt.
REQ-021 Taken-branch decode: bs=3'b001 taken if zero; 3'b010 if !zero; 3'b011 if neg; 3'b100 if !neg; any other value, including X/Z, SHALL mean not taken.
REQ-022 When instr_valid=1, next pc SHALL be pc+1+sign_extend(off) if the branch is taken, else pc+1, modulo 2^PC_W (wrap-around, no error).
REQ-023 When instr_valid=1 and halt=1, next pc SHALL be pc+1 and the branch decode SHALL be ignored (halt wins).
REQ-024 When instr_valid=0, pc SHALL hold.
REQ-025 Latency: a taken branch SHALL present its target on pc the cycle after the branch instruction executes; there are no delay slots and no bubbles.
REQ-026 Offset arithmetic SHALL sign-extend off to PC_W bits before addition; off=6'b111111 SHALL yield pc+0.
REQ-027 halted SHALL assert the cycle after halt retires and stay high until leaving HALTED.
REQ-028 Resume from HALTED SHALL execute from the instruction after the halt.

Reset
REQ-029 rst=1 SHALL override all other inputs in the same cycle.
REQ-030 Reset values: pc=RESET_PC, state=IDLE, instr_valid=0, halted=0, retire_cnt=0.
REQ-031 Reset asserted mid-RUN or mid-STEP SHALL abort the current instruction; no pc update or count from that cycle.

Configuration
REQ-032 Macro FETCH_RETIRE_CNT_EN SHALL control the retire counter.
REQ-033 Macro defined: retire_cnt SHALL increment by 1 each cycle instr_valid=1 (halt included), saturating at 16'hFFFF.
REQ-034 Macro undefined: retire_cnt SHALL be tied to 16'h0000, with no counter flops.

Verification
REQ-035 Reset, then run=1 one cycle, straight-line code, no halt -> pc 0,1,2,... from the cycle after run; instr_valid=1; pc wraps 255->0.
REQ-036 At pc=10: bs=3'b001, zero=1, off=6'b111100 -> next pc=7. Same instruction with zero=0 -> next pc=11.
REQ-037 At pc=20: halt=1 -> halted=1 and pc=21 next cycle, pc holds; run=1 -> RUN and resume at 21.
REQ-038 In HALTED, step=1 one cycle -> exactly one cycle with instr_valid=1 then HALTED; pc advances by 1 (or by branch target).
REQ-039 rst=1 in RUN with a taken branch at pc=5 -> next cycle pc=RESET_PC, IDLE, instr_valid=0.
REQ-040 With FETCH_RETIRE_CNT_EN: 5 instructions then halt -> retire_cnt=6; without the macro -> retire_cnt=0 throughout.

Source files
------------

// File: rtl/fetch_unit_if.sv
// ----------------------------------------------------------------------------
// fetch_unit_if -- control/bus bundle between the decoder/ALU side and the
// fetch unit.
//
// Signals (all sampled/updated on the rising clock edge of the fetch unit):
//   run         master->slave  start/resume request
//   step        master->slave  single-instruction-step request
//   bs[2:0]     master->slave  branch select from the decoder
//   off[5:0]    master->slave  two's-complement branch offset
//   halt        master->slave  halt flag of the current instruction
//   zero, neg   master->slave  ALU flags of the current instruction
//   pc          slave->master  current PC (instruction-memory word address)
//   instr_valid slave->master  current instruction is executing this cycle
//   halted      slave->master  unit is in HALTED
//   retire_cnt  slave->master  retired-instruction count
//   state_dbg   slave->master  encoded FSM state, for debug/checkers
//
// Qualifier semantics: instr_valid is a pure qualifier with no ready/backpressure.
// The decoder fields (bs, off, halt) and ALU flags are only looked at in a
// cycle where instr_valid=1; in every other cycle they are don't-care.
// ----------------------------------------------------------------------------
interface fetch_unit_if #(
  parameter int PC_W = 8
);
  logic            run;
  logic            step;
  logic [2:0]      bs;
  logic [5:0]      off;
  logic            halt;
  logic            zero;
  logic            neg;
  logic [PC_W-1:0] pc;
  logic            instr_valid;
  logic            halted;
  logic [15:0]     retire_cnt;
  logic [1:0]      state_dbg;

  modport master (
    output run, step, bs, off, halt, zero, neg,
    input  pc, instr_valid, halted, retire_cnt, state_dbg
  );

  modport slave (
    input  run, step, bs, off, halt, zero, neg,
    output pc, instr_valid, halted, retire_cnt, state_dbg
  );
endinterface

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit -- program-counter sequencer with run / single-step / halt control
// and conditional PC-relative branches.
//
// Parameters:
//   PC_W      program counter width (word address width), default 8
//   RESET_PC  PC value loaded by reset, default 0
//
// Ports:
//   clk   single clock, all state changes on its rising edge
//   rst   synchronous active-high reset; overrides every other input
//   bus   fetch_unit_if.slave (see fetch_unit_if.sv for the signal list)
//
// Optional feature:
//   FETCH_RETIRE_CNT_EN  when defined, retire_cnt is a 16-bit saturating count
//                        of cycles with instr_valid=1; when undefined it is
//                        tied to zero and no counter flops exist.
//
// FSM encoding (visible on bus.state_dbg): IDLE=0, RUN=1, STEP=2, HALTED=3.
// ----------------------------------------------------------------------------
module fetch_unit #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic        clk,
  input logic        rst,
  fetch_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_STEP   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            instr_valid;
  logic            taken;
  logic [PC_W-1:0] off_ext;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // ------------------------------------------------------- next state / pc
  always_comb begin
    state_d = state_q;
    case (state_q)
      // run has priority over step when both are requested
      S_IDLE, S_HALTED: begin
        if (bus.run)       state_d = S_RUN;
        else if (bus.step) state_d = S_STEP;
      end
      S_RUN: begin
        if (bus.halt) state_d = S_HALTED;
      end
      // a step is always exactly one instruction, halt or not
      S_STEP:  state_d = S_HALTED;
      default: state_d = S_IDLE;
    endcase
  end

  assign instr_valid = (state_q == S_RUN) || (state_q == S_STEP);

  // Branch condition decode. Unlisted encodings (and unknown bs in
  // simulation, which falls through to default) mean not taken.
  always_comb begin
    taken = 1'b0;
    case (bus.bs)
      3'b001:  taken = bus.zero;
      3'b010:  taken = !bus.zero;
      3'b011:  taken = bus.neg;
      3'b100:  taken = !bus.neg;
      default: taken = 1'b0;
    endcase
  end

  // Sign-extend the 6-bit offset to the PC width; the add below wraps
  // naturally modulo 2^PC_W.
  assign off_ext = PC_W'($signed(bus.off));

  always_comb begin
    pc_d = pc_q;
    if (instr_valid) begin
      // halt wins over any branch decode of the same instruction
      if (taken && !bus.halt) pc_d = pc_q + PC_W'(1) + off_ext;
      else                    pc_d = pc_q + PC_W'(1);
    end
  end

  // -------------------------------------------------------- retire counter
`ifdef FETCH_RETIRE_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (instr_valid && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 16'h0000;
    else     cnt_q <= cnt_d;
  end

  assign bus.retire_cnt = cnt_q;
`else
  assign bus.retire_cnt = 16'h0000;
`endif

  // ---------------------------------------------------------------- outputs
  assign bus.pc          = pc_q;
  assign bus.instr_valid = instr_valid;
  assign bus.halted      = (state_q == S_HALTED);
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit -- self-checking bench for fetch_unit (PC_W=8, RESET_PC=0).
// Each driven cycle pushes the expected post-edge outputs from a small
// behavioural model onto exp_q; they are popped and compared one time unit
// after the rising edge. Directed scenarios add fixed-value checks.
// ----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int         PC_W     = 8;
  localparam logic [7:0] RESET_PC = 8'd0;
  localparam int         W        = 28; // {pc, iv, halted, cnt, state}

  // ---------------------------------------------------------- clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if #(.PC_W(PC_W)) fu ();

  fetch_unit #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (fu.slave)
  );

  // ------------------------------------------------------------ scoreboard
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // model state
  logic [7:0]  m_pc  = RESET_PC;
  logic [1:0]  m_st  = 2'd0;
  logic [15:0] m_cnt = 16'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, ru, st, input logic [2:0] b,
                            input logic [5:0] o, input logic h, z, n);
    logic iv, tk;
    if (r) begin
      m_pc  = RESET_PC;
      m_st  = 2'd0;
      m_cnt = 16'd0;
    end else begin
      iv = (m_st == 2'd1) || (m_st == 2'd2);
      if (iv) begin
        case (b)
          3'b001:  tk = z;
          3'b010:  tk = !z;
          3'b011:  tk = n;
          3'b100:  tk = !n;
          default: tk = 1'b0;
        endcase
        if (h) tk = 1'b0;
        m_pc = m_pc + 8'd1 + (tk ? {{2{o[5]}}, o} : 8'd0);
`ifdef FETCH_RETIRE_CNT_EN
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
      end
      case (m_st)
        2'd0, 2'd3: if (ru) m_st = 2'd1; else if (st) m_st = 2'd2;
        2'd1:       if (h) m_st = 2'd3;
        default:    m_st = 2'd3;
      endcase
    end
  endtask

  // ---------------------------------------------------------------- driver
  task automatic drive(input logic r, ru, st, input logic [2:0] b,
                       input logic [5:0] o, input logic h, z, n);
    logic [W-1:0] e;
    rst     = r;
    fu.run  = ru;
    fu.step = st;
    fu.bs   = b;
    fu.off  = o;
    fu.halt = h;
    fu.zero = z;
    fu.neg  = n;
    model_step(r, ru, st, b, o, h, z, n);
    exp_q.push_back({m_pc, (m_st == 2'd1) || (m_st == 2'd2), m_st == 2'd3, m_cnt, m_st});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("pc",          32'(fu.pc),          32'(e[27:20]));
      check("instr_valid", 32'(fu.instr_valid), 32'(e[19]));
      check("halted",      32'(fu.halted),      32'(e[18]));
      check("retire_cnt",  32'(fu.retire_cnt),  32'(e[17:2]));
      check("state",       32'(fu.state_dbg),   32'(e[1:0]));
    end
  endtask

  task automatic idle_cyc();        drive(1'b0, 1'b0, 1'b0, 3'b000, 6'd0, 1'b0, 1'b0, 1'b0); endtask
  task automatic do_reset();        drive(1'b1, 1'b0, 1'b0, 3'b000, 6'd0, 1'b0, 1'b0, 1'b0); endtask
  task automatic do_run();          drive(1'b0, 1'b1, 1'b0, 3'b000, 6'd0, 1'b0, 1'b0, 1'b0); endtask
  task automatic do_halt();         drive(1'b0, 1'b0, 1'b0, 3'b000, 6'd0, 1'b1, 1'b0, 1'b0); endtask
  task automatic straight(input int k);
    for (int i = 0; i < k; i++) idle_cyc();
  endtask

  // -------------------------------------------------------------- stimulus
  initial begin
    rst = 1'b1;
    fu.run = 1'b0; fu.step = 1'b0; fu.bs = 3'b000; fu.off = 6'd0;
    fu.halt = 1'b0; fu.zero = 1'b0; fu.neg = 1'b0;

    // reset values
    do_reset();
    check("rst_pc", 32'(fu.pc), 32'd0);
    check("rst_iv", 32'(fu.instr_valid), 32'd0);
    check("rst_halted", 32'(fu.halted), 32'd0);
    check("rst_cnt", 32'(fu.retire_cnt), 32'd0);

    // start and straight-line execution
    do_run();
    check("run_pc0", 32'(fu.pc), 32'd0);
    check("run_iv", 32'(fu.instr_valid), 32'd1);
    straight(10);
    check("pc10", 32'(fu.pc), 32'd10);

    // beq taken backwards: 10 + 1 - 4 = 7
    drive(1'b0, 1'b0, 1'b0, 3'b001, 6'b111100, 1'b0, 1'b1, 1'b0);
    check("beq_taken", 32'(fu.pc), 32'd7);
    straight(3);
    drive(1'b0, 1'b0, 1'b0, 3'b001, 6'b111100, 1'b0, 1'b0, 1'b0);
    check("beq_not_taken", 32'(fu.pc), 32'd11);

    // halt at 20, hold, resume at 21
    straight(9);
    check("pc20", 32'(fu.pc), 32'd20);
    do_halt();
    check("halt_pc", 32'(fu.pc), 32'd21);
    check("halt_flag", 32'(fu.halted), 32'd1);
    check("halt_iv", 32'(fu.instr_valid), 32'd0);
    straight(3);
    check("halt_hold", 32'(fu.pc), 32'd21);
    do_run();
    check("resume_pc", 32'(fu.pc), 32'd21);
    check("resume_iv", 32'(fu.instr_valid), 32'd1);
    idle_cyc();
    check("resume_next", 32'(fu.pc), 32'd22);

    // single step from HALTED
    do_halt();
    check("halt2_pc", 32'(fu.pc), 32'd23);
    drive(1'b0, 1'b0, 1'b1, 3'b000, 6'd0, 1'b0, 1'b0, 1'b0);
    check("step_iv", 32'(fu.instr_valid), 32'd1);
    idle_cyc();
    check("step_done_pc", 32'(fu.pc), 32'd24);
    check("step_done_halted", 32'(fu.halted), 32'd1);
    // step with taken branch: 24 + 1 + 2 = 27
    drive(1'b0, 1'b0, 1'b1, 3'b000, 6'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 3'b001, 6'b000010, 1'b0, 1'b1, 1'b0);
    check("step_branch_pc", 32'(fu.pc), 32'd27);
    check("step_branch_halted", 32'(fu.halted), 32'd1);

    // run and step together -> RUN
    drive(1'b0, 1'b1, 1'b1, 3'b000, 6'd0, 1'b0, 1'b0, 1'b0);
    check("run_step_prio", 32'(fu.state_dbg), 32'd1);
    // off = -1 with blt taken -> pc + 0
    drive(1'b0, 1'b0, 1'b0, 3'b011, 6'b111111, 1'b0, 1'b0, 1'b1);
    check("off_minus1", 32'(fu.pc), 32'd27);
    // unlisted bs -> not taken
    drive(1'b0, 1'b0, 1'b0, 3'b111, 6'b111100, 1'b0, 1'b1, 1'b1);
    check("bs_other", 32'(fu.pc), 32'd28);
    // bge (!neg) taken forward: 28 + 1 + 5 = 34
    drive(1'b0, 1'b0, 1'b0, 3'b100, 6'd5, 1'b0, 1'b0, 1'b0);
    check("bge_taken", 32'(fu.pc), 32'd34);
    // halt wins over taken branch
    drive(1'b0, 1'b0, 1'b0, 3'b001, 6'b111100, 1'b1, 1'b1, 1'b0);
    check("halt_wins_pc", 32'(fu.pc), 32'd35);
    check("halt_wins_halted", 32'(fu.halted), 32'd1);

    // reset mid-RUN with a taken branch at pc 5
    do_reset();
    do_run();
    straight(5);
    check("pc5", 32'(fu.pc), 32'd5);
    drive(1'b1, 1'b0, 1'b0, 3'b010, 6'd7, 1'b0, 1'b0, 1'b0);
    check("rst_run_pc", 32'(fu.pc), 32'(RESET_PC));
    check("rst_run_iv", 32'(fu.instr_valid), 32'd0);
    check("rst_run_state", 32'(fu.state_dbg), 32'd0);

    // retire count: 5 instructions then halt
    do_run();
    straight(5);
    do_halt();
`ifdef FETCH_RETIRE_CNT_EN
    check("retire_6", 32'(fu.retire_cnt), 32'd6);
`else
    check("retire_tied", 32'(fu.retire_cnt), 32'd0);
`endif
    straight(2);

    // wrap 255 -> 0
    do_reset();
    do_run();
    straight(255);
    check("pc255", 32'(fu.pc), 32'd255);
    idle_cyc();
    check("pc_wrap", 32'(fu.pc), 32'd0);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 31) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0),
            3'($urandom_range(0, 7)),
            6'($urandom_range(0, 63)),
            ($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
